// File: rtl/apb_master.sv
// APB initiator: converts single-word command requests into APB transfers,
// returns read data/error as a one-cycle response, aborts stalled transfers.
module apb_master #(
  parameter int DW          = 8,
  parameter int BW          = 32,
  parameter int ADDR_W      = 16,
  parameter int MAX_DIM     = BW / DW,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_write_i,
  input  logic [ADDR_W-1:0]  cmd_addr_i,
  input  logic [BW-1:0]      cmd_wdata_i,
  input  logic [MAX_DIM-1:0] cmd_strb_i,
  output logic               rsp_valid_o,
  output logic [BW-1:0]      rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               rsp_timeout_o,
  output logic               psel_o,
  output logic               penable_o,
  output logic               pwrite_o,
  output logic [ADDR_W-1:0]  paddr_o,
  output logic [BW-1:0]      pwdata_o,
  output logic [MAX_DIM-1:0] pstrb_o,
  input  logic [BW-1:0]      prdata_i,
  input  logic               pready_i,
  input  logic               pslverr_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [15:0]          wd_q, wd_d;
  logic                 cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic                 psel_d, penable_d, pwrite_d, busy_d;
  logic [BW-1:0]        rsp_rdata_d, pwdata_d;
  logic [ADDR_W-1:0]    paddr_d;
  logic [MAX_DIM-1:0]   pstrb_d;
  logic                 wd_expire;

  // The expiring edge is the TIMEOUT_CYC-th ACCESS edge without pready.
  assign wd_expire = (TIMEOUT_CYC != 0) && (wd_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    cmd_ready_d   = cmd_ready_o;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_o;
    rsp_err_d     = rsp_err_o;
    rsp_timeout_d = rsp_timeout_o;
    psel_d        = psel_o;
    penable_d     = penable_o;
    pwrite_d      = pwrite_o;
    paddr_d       = paddr_o;
    pwdata_d      = pwdata_o;
    pstrb_d       = pstrb_o;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        if (cmd_valid_i) begin
          pwrite_d    = cmd_write_i;
          paddr_d     = cmd_addr_i;
          pwdata_d    = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d     = cmd_write_i ? cmd_strb_i : '0;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wd_d      = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rsp_err_d     = pslverr_i;
          if (!pwrite_o) rsp_rdata_d = prdata_i;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (TIMEOUT_CYC != 0) begin
          wd_d = wd_q + 16'd1;
          if (wd_expire) begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      cmd_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      pwrite_o      <= 1'b0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pstrb_o       <= '0;
      busy_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      cmd_ready_o   <= cmd_ready_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_rdata_o   <= rsp_rdata_d;
      rsp_err_o     <= rsp_err_d;
      rsp_timeout_o <= rsp_timeout_d;
      psel_o        <= psel_d;
      penable_o     <= penable_d;
      pwrite_o      <= pwrite_d;
      paddr_o       <= paddr_d;
      pwdata_o      <= pwdata_d;
      pstrb_o       <= pstrb_d;
      busy_o        <= busy_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master with an in-bench APB slave
// and a transaction-level response model.
module tb_apb_master;
  localparam int BW = 32, ADDR_W = 16, MAX_DIM = 4, TO = 16;

  logic               clk, reset_ni;
  logic               cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [BW-1:0]      cmd_wdata;
  logic [MAX_DIM-1:0] cmd_strb;
  logic               rsp_valid, rsp_err, rsp_timeout;
  logic [BW-1:0]      rsp_rdata;
  logic               psel, penable, pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [BW-1:0]      pwdata, prdata;
  logic [MAX_DIM-1:0] pstrb;
  logic               pready, pslverr, busy;

  apb_master #(.DW(8), .BW(BW), .ADDR_W(ADDR_W), .MAX_DIM(MAX_DIM), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_pass = 0;
  logic [BW-1:0] ref_rdata;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One command, starting at a negedge with the DUT idle. The slave raises
  // pready after 'waits' stalled ACCESS cycles.
  task automatic xfer(input bit wr, input logic [ADDR_W-1:0] a, input logic [BW-1:0] wd,
                      input logic [MAX_DIM-1:0] st, input int waits, input bit err,
                      input logic [BW-1:0] rd, input bit keep, output int rsp_cyc);
    bit exp_to, done;
    int k;
    exp_to  = (TO != 0) && (waits >= TO);
    rsp_cyc = -1;
    check_eq("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    check_eq("setup_sel_en", {psel, penable}, 2'b10);
    check_eq("setup_paddr", paddr, a);
    check_eq("setup_pwrite", pwrite, wr);
    check_eq("setup_pwdata", pwdata, wr ? wd : '0);
    check_eq("setup_pstrb", pstrb, wr ? st : '0);
    check_eq("setup_ready_busy", {cmd_ready, busy}, 2'b01);
    @(negedge clk);
    check_eq("access_sel_en", {psel, penable}, 2'b11);
    done = 1'b0;
    for (k = 0; k < 64 && !done; k++) begin
      pready  = (k == waits);
      prdata  = (k == waits) ? rd : $urandom;
      pslverr = (k == waits) ? err : 1'($urandom);
      @(negedge clk);
      pready = 1'b0; pslverr = 1'b0;
      if (rsp_valid) begin
        done = 1'b1;
        rsp_cyc = cyc;
        check_eq("complete_cycle", k, exp_to ? TO - 1 : waits);
        if (!exp_to && !wr) ref_rdata = rd;
        check_eq("rsp_err", rsp_err, exp_to ? 1'b1 : err);
        check_eq("rsp_timeout", rsp_timeout, exp_to);
        check_eq("rsp_rdata", rsp_rdata, ref_rdata);
        check_eq("rsp_sel_en", {psel, penable}, 2'b00);
        check_eq("rsp_ready_busy", {cmd_ready, busy}, 2'b01);
      end else begin
        check_eq("wait_sel_en", {psel, penable}, 2'b11);
        check_eq("wait_paddr", paddr, a);
      end
    end
    check_eq("rsp_bound", done, 1);
    @(negedge clk);
    check_eq("back_idle", {rsp_valid, cmd_ready, busy, psel}, 4'b0100);
  endtask

  initial begin
    int c0, c1, c2, r, w;
    reset_ni = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; prdata = '0; pready = 0; pslverr = 0; ref_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctrl", {cmd_ready, psel, penable, busy, rsp_valid, rsp_err, rsp_timeout, pwrite},
             8'b1000_0000);
    check_eq("rst_data", {rsp_rdata, pwdata}, 64'h0);
    check_eq("rst_addr_strb", {paddr, pstrb}, 20'h0);
    reset_ni = 1'b1;
    @(negedge clk);

    xfer(1, 16'h0004, 32'h0000_0003, 4'hF, 0, 0, 32'h0, 0, c0);
    xfer(0, 16'h000C, 32'h1234_5678, 4'hA, 3, 0, 32'hDEAD_BEEF, 0, c0);
    xfer(1, 16'h0000, 32'hCAFE_0001, 4'h3, 0, 1, 32'h0, 0, c0);
    xfer(0, 16'h0008, 32'h0, 4'h0, 1, 0, 32'h0BAD_F00D, 0, c0);
    xfer(0, 16'h0010, 32'h0, 4'h0, 100, 0, 32'h5555_AAAA, 0, c0);
    xfer(1, 16'h0014, 32'h7777_7777, 4'h5, TO, 0, 32'h0, 0, c0);
    xfer(0, 16'h0018, 32'h0, 4'h0, TO - 1, 0, 32'h1357_9BDF, 0, c0);

    xfer(1, 16'h0020, 32'h1111_1111, 4'hF, 0, 0, 32'h0, 1, c0);
    xfer(1, 16'h0024, 32'h2222_2222, 4'hF, 0, 0, 32'h0, 1, c1);
    xfer(0, 16'h0028, 32'h0, 4'h0, 0, 0, 32'h3333_3333, 0, c2);
    check_eq("b2b_space1", c1 - c0, 4);
    check_eq("b2b_space2", c2 - c1, 4);

    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    pready = 1'b0;
    @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    ref_rdata = '0;
    check_eq("midrst_ctrl", {psel, penable, busy, rsp_valid, cmd_ready}, 5'b00001);
    check_eq("midrst_rdata", rsp_rdata, ref_rdata);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
    check_eq("postrst", {rsp_valid, cmd_ready, busy}, 3'b010);
    xfer(0, 16'h0030, 32'h0, 4'h0, 2, 0, 32'hFEED_FACE, 0, c0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      w = (r < 7) ? $urandom_range(0, 3) : $urandom_range(TO - 2, TO + 2);
      xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom), w, 1'($urandom), $urandom, 0, c0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule
